// File: rtl/ct_resolve_unit.sv
// ct_resolve_unit: control-transfer resolver feeding PC redirects.
//  - X path resolves JCC / JMP_REL / CALL_REL / JMP_REG combinationally.
//  - M path resolves RET / JMP_MEM when the target load returns, with a
//    bounded wait (MAX_WAIT) and a one-cycle ct_err pulse on timeout.
//  - Optional feature macro: CT_STATS_EN adds saturating redirect counters.
// Handshake: m_load_valid is a single-cycle valid with no back-pressure; the
// cycle it is high in PEND the target is consumed and the FSM returns to IDLE.
// The FSM state is visible as the internal signal fsm_state.
module ct_resolve_unit #(
  parameter int INSN_BYTES = 4,
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_W     = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        hlt,
  input  logic        x_valid,
  input  logic [2:0]  x_ct_type,
  input  logic [3:0]  x_cond,
  input  logic [3:0]  x_flags,
  input  logic [31:0] x_pc,
  input  logic [31:0] x_imm,
  input  logic [31:0] x_rs_val,
  input  logic        m_load_valid,
  input  logic [31:0] m_load_data,
  output logic        ct_taken_x,
  output logic [31:0] ct_pc_x,
  output logic        ct_taken_m,
  output logic [31:0] ct_pc_m,
  output logic        x_stall,
  output logic        ct_err,
  output logic [31:0] stat_taken_x,
  output logic [31:0] stat_taken_m
);

  localparam logic [2:0] CT_JCC      = 3'd1;
  localparam logic [2:0] CT_JMP_REL  = 3'd2;
  localparam logic [2:0] CT_CALL_REL = 3'd3;
  localparam logic [2:0] CT_JMP_REG  = 3'd4;
  localparam logic [2:0] CT_RET      = 3'd5;
  localparam logic [2:0] CT_JMP_MEM  = 3'd6;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  state_t            state_q, state_d;
  state_t            fsm_state;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_d;
  logic              clear;
  logic              cond_sel;
  logic              cond_true;
  logic              x_live;
  logic              x_is_mem;
  logic [31:0]       rel_target;

  // hlt acts exactly like reset
  assign clear     = ~n_rst | hlt;
  assign fsm_state = state_q;

  // Flags are {OF,SF,ZF,CF}
  always_comb begin
    cond_sel = 1'b0;
    case (x_cond[3:1])
      3'd0: cond_sel = x_flags[3];
      3'd1: cond_sel = x_flags[0];
      3'd2: cond_sel = x_flags[1];
      3'd3: cond_sel = x_flags[0] | x_flags[1];
      3'd4: cond_sel = x_flags[2];
      3'd5: cond_sel = x_flags[2] ^ x_flags[3];
      3'd6: cond_sel = (x_flags[2] ^ x_flags[3]) | x_flags[1];
      default: cond_sel = 1'b1;
    endcase
  end

  assign cond_true  = cond_sel ^ x_cond[0];
  assign x_live     = x_valid & ~x_stall & ~ct_taken_m;
  assign x_is_mem   = (x_ct_type == CT_RET) | (x_ct_type == CT_JMP_MEM);
  assign rel_target = x_pc + 32'(INSN_BYTES) + x_imm;

  // State register, wait counter and registered error pulse
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      ct_err     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ct_err     <= err_d;
    end
  end

  // Next-state: enter PEND on a memory-sourced transfer, leave on load or timeout
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (x_live && x_is_mem) begin
          state_d    = ST_PEND;
          wait_cnt_d = '0;
        end
      end
      ST_PEND: begin
        if (m_load_valid) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Outputs: M redirect and stall from FSM, X redirect from the live instruction
  always_comb begin
    ct_taken_m = (state_q == ST_PEND) & m_load_valid;
    ct_pc_m    = ct_taken_m ? m_load_data : 32'd0;
    x_stall    = (state_q == ST_PEND) & ~m_load_valid;
    ct_taken_x = 1'b0;
    ct_pc_x    = 32'd0;
    if (x_valid && !x_stall && !ct_taken_m) begin
      case (x_ct_type)
        CT_JCC: begin
          ct_taken_x = cond_true;
          ct_pc_x    = cond_true ? rel_target : 32'd0;
        end
        CT_JMP_REL, CT_CALL_REL: begin
          ct_taken_x = 1'b1;
          ct_pc_x    = rel_target;
        end
        CT_JMP_REG: begin
          ct_taken_x = 1'b1;
          ct_pc_x    = x_rs_val;
        end
        default: begin
          ct_taken_x = 1'b0;
          ct_pc_x    = 32'd0;
        end
      endcase
    end
  end

`ifdef CT_STATS_EN
  logic [31:0] stat_x_q, stat_m_q;

  // Saturating redirect counters
  always_ff @(posedge clk) begin
    if (clear) begin
      stat_x_q <= 32'd0;
      stat_m_q <= 32'd0;
    end else begin
      if (ct_taken_x && stat_x_q != 32'hFFFF_FFFF) stat_x_q <= stat_x_q + 32'd1;
      if (ct_taken_m && stat_m_q != 32'hFFFF_FFFF) stat_m_q <= stat_m_q + 32'd1;
    end
  end

  assign stat_taken_x = stat_x_q;
  assign stat_taken_m = stat_m_q;
`else
  assign stat_taken_x = 32'd0;
  assign stat_taken_m = 32'd0;
`endif

endmodule
